sevseg_scheduler: RTL

Display-source scheduler in front of `seven_segment`: shares the single 32-bit eight-digit display among `N_SRC` miner status sources (nonce, hash count, difficulty, temperature, etc.). Sources rotate round-robin with a fixed dwell time. A one-shot alert, such as a golden nonce found, pre-empts the rotation and is held for a fixed time. The registered `disp_data` output drives `seven_segment`'s `data` input directly.

---
 rtl/sevseg_pkg.sv | 12 +
 rtl/rr_next_valid.sv | 32 +++
 rtl/sevseg_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment display source scheduler.
package sevseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        ALERT = 2'd2
    } state_t;

    localparam int DISP_W = 32;

endpackage

// File: rtl/rr_next_valid.sv
// Round-robin search: first set bit strictly after cur with wrap-around,
// falling back to cur itself when it is the only set bit.
module rr_next_valid #(
    parameter int N_SRC = 4,
    parameter int SEL_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] valid,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] next,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        next  = cur;
        found = 1'b0;
        idx   = '0;
        // i == N_SRC lands back on cur, covering the single-valid case
        for (int i = 1; i <= N_SRC; i++) begin
            idx = SEL_W'((int'(cur) + i) % N_SRC);
            if (!found && valid[idx]) begin
                next  = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/sevseg_scheduler.sv
// Rotates miner status sources onto the eight-digit display with a fixed
// dwell time; a latched alert pre-empts the rotation for a fixed hold time.
module sevseg_scheduler
    import sevseg_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int ALERT_CYCLES = 300_000_000,
    parameter int SEL_W        = $clog2(N_SRC)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_SRC*DISP_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic                    alert,
    input  logic [DISP_W-1:0]       alert_data,
    input  logic                    alert_clear,
    output logic [DISP_W-1:0]       disp_data,
    output logic [SEL_W-1:0]        disp_sel,
    output logic                    alert_active
);

    localparam int DWL_W = $clog2(DWELL_CYCLES);
    localparam int ALR_W = $clog2(ALERT_CYCLES);
    localparam logic [DWL_W-1:0] DWELL_LAST = DWL_W'(DWELL_CYCLES - 1);
    localparam logic [ALR_W-1:0] ALERT_LAST = ALR_W'(ALERT_CYCLES - 1);

    state_t            state, state_n;
    logic [SEL_W-1:0]  sel, sel_n;
    logic [DWL_W-1:0]  dwell_cnt, dwell_n;
    logic [ALR_W-1:0]  alert_cnt, alert_cnt_n;
    logic [DISP_W-1:0] alert_reg, alert_reg_n;
    logic [DISP_W-1:0] disp_n;

    logic [DISP_W-1:0] src_arr [N_SRC];
    logic [SEL_W-1:0]  rr_cur;
    logic [SEL_W-1:0]  nxt;
    logic              any_valid;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign src_arr[g] = src_data[DISP_W*g +: DISP_W];
    end

    // From IDLE, searching after the top index yields the lowest valid source
    assign rr_cur = (state == IDLE) ? SEL_W'(N_SRC - 1) : sel;

    rr_next_valid #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_rr (
        .valid (src_valid),
        .cur   (rr_cur),
        .next  (nxt),
        .any   (any_valid)
    );

    always_comb begin
        state_n     = state;
        sel_n       = sel;
        dwell_n     = dwell_cnt;
        alert_cnt_n = alert_cnt;
        alert_reg_n = alert_reg;
        if (alert) begin
            state_n     = ALERT;
            alert_reg_n = alert_data;
            alert_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state_n = SHOW;
                        sel_n   = nxt;
                        dwell_n = '0;
                    end
                end
                SHOW: begin
                    if (!any_valid) begin
                        state_n = IDLE;
                        dwell_n = '0;
                    end else if (!src_valid[sel] || dwell_cnt == DWELL_LAST) begin
                        sel_n   = nxt;
                        dwell_n = '0;
                    end else begin
                        dwell_n = dwell_cnt + 1'b1;
                    end
                end
                ALERT: begin
                    if (alert_clear || alert_cnt == ALERT_LAST) begin
                        alert_cnt_n = '0;
                        dwell_n     = '0;
                        if (src_valid[sel]) begin
                            state_n = SHOW;
                        end else if (any_valid) begin
                            state_n = SHOW;
                            sel_n   = nxt;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        alert_cnt_n = alert_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        case (state_n)
            SHOW:    disp_n = src_arr[sel_n];
            ALERT:   disp_n = alert_reg_n;
            default: disp_n = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sel          <= '0;
            dwell_cnt    <= '0;
            alert_cnt    <= '0;
            alert_reg    <= '0;
            disp_data    <= '0;
            alert_active <= 1'b0;
        end else begin
            state        <= state_n;
            sel          <= sel_n;
            dwell_cnt    <= dwell_n;
            alert_cnt    <= alert_cnt_n;
            alert_reg    <= alert_reg_n;
            disp_data    <= disp_n;
            alert_active <= (state_n == ALERT);
        end
    end

    assign disp_sel = sel;

endmodule
